// File: rtl/cve2_pkg.sv
// Shared types and constants for the hardware-loop controller.
package cve2_pkg;

  typedef enum logic {
    HWLP_IDLE      = 1'b0,
    HWLP_JUMP_PEND = 1'b1
  } hwlp_state_e;

  localparam logic [31:0] HWLP_INSTR_BYTES = 32'd4;

endpackage

// File: rtl/cve2_hwloop_match.sv
// Per-loop end-of-body match with innermost-first priority and exit-chain handling.
module cve2_hwloop_match
  import cve2_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic [31:0]              pc_i,
  input  logic [N_REGS-1:0][31:0]  end_addr_i,
  input  logic [N_REGS-1:0][31:0]  counter_i,
  output logic [N_REGS-1:0]        dec_o,
  output logic                     jump_o,
  output logic [N_REG_BITS-1:0]    idx_o
);

  logic [N_REGS-1:0] match;

  always_comb begin
    for (int k = 0; k < N_REGS; k++) begin
      // A zero end address would wrap to 0xFFFFFFFC; treat it as "no loop".
      match[k] = (counter_i[k] != 32'd0) && (end_addr_i[k] != 32'd0) &&
                 (pc_i == end_addr_i[k] - HWLP_INSTR_BYTES);
    end
  end

  // Walk from the innermost loop; an exiting loop lets the next one be tested,
  // a jumping loop ends the walk.
  always_comb begin
    logic cont;
    cont   = 1'b1;
    dec_o  = '0;
    jump_o = 1'b0;
    idx_o  = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (cont && match[k]) begin
        dec_o[k] = 1'b1;
        if (counter_i[k] > 32'd1) begin
          jump_o = 1'b1;
          idx_o  = k[N_REG_BITS-1:0];
          cont   = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cve2_hwloop_controller.sv
// Hardware-loop sequencer: decrements loop counters on retire of the last body
// instruction and holds a fetch redirect to the loop start until IF accepts it.
module cve2_hwloop_controller
  import cve2_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              id_pc_i,
  input  logic                     id_instr_valid_i,
  input  logic                     id_ready_i,
  input  logic                     flush_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_counter_i,
  input  logic                     if_ready_i,
  output logic [N_REGS-1:0]        hwlp_dec_cnt_o,
  output logic                     hwlp_valid_o,
  output logic                     hwlp_jump_o,
  output logic [31:0]              hwlp_target_o,
  output logic                     hwlp_busy_o
);

  hwlp_state_e            state_q, state_d;
  logic [31:0]            target_q, target_d;
  logic [N_REGS-1:0]      sel_dec;
  logic                   sel_jump;
  logic [N_REG_BITS-1:0]  sel_idx;
  logic                   retire;

  cve2_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .pc_i       (id_pc_i),
    .end_addr_i (hwlp_end_addr_i),
    .counter_i  (hwlp_counter_i),
    .dec_o      (sel_dec),
    .jump_o     (sel_jump),
    .idx_o      (sel_idx)
  );

  // No new decision while a redirect is outstanding.
  assign retire = id_instr_valid_i & id_ready_i & ~flush_i & (state_q == HWLP_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HWLP_IDLE;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      HWLP_IDLE: begin
        if (retire && sel_jump) begin
          state_d  = HWLP_JUMP_PEND;
          target_d = hwlp_start_addr_i[sel_idx];
        end
      end
      HWLP_JUMP_PEND: begin
        // A flush drops the redirect; the committed decrement stays.
        if (flush_i || if_ready_i) state_d = HWLP_IDLE;
      end
      default: state_d = HWLP_IDLE;
    endcase
  end

  always_comb begin
    hwlp_dec_cnt_o = retire ? sel_dec : '0;
    hwlp_valid_o   = retire & (|sel_dec);
    hwlp_jump_o    = (state_q == HWLP_JUMP_PEND);
    hwlp_busy_o    = (state_q == HWLP_JUMP_PEND);
    hwlp_target_o  = target_q;
  end

endmodule

// File: tb/tb_cve2_hwloop_controller.sv
// Directed bench for the hardware-loop controller; the bench plays the register file.
module tb_cve2_hwloop_controller;

  logic             clk;
  logic             rst_n;
  logic [31:0]      id_pc;
  logic             id_valid;
  logic             id_ready;
  logic             flush;
  logic [1:0][31:0] start_addr;
  logic [1:0][31:0] end_addr;
  logic [1:0][31:0] counter;
  logic             if_ready;
  logic [1:0]       dec;
  logic             dvalid;
  logic             jump;
  logic [31:0]      target;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  cve2_hwloop_controller #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_pc_i           (id_pc),
    .id_instr_valid_i  (id_valid),
    .id_ready_i        (id_ready),
    .flush_i           (flush),
    .hwlp_start_addr_i (start_addr),
    .hwlp_end_addr_i   (end_addr),
    .hwlp_counter_i    (counter),
    .if_ready_i        (if_ready),
    .hwlp_dec_cnt_o    (dec),
    .hwlp_valid_o      (dvalid),
    .hwlp_jump_o       (jump),
    .hwlp_target_o     (target),
    .hwlp_busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_loop(input int k, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] c);
    start_addr[k] = s;
    end_addr[k]   = e;
    counter[k]    = c;
  endtask

  task automatic retire(input logic [31:0] pc);
    id_pc    = pc;
    id_valid = 1'b1;
    id_ready = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_pc = '0; id_valid = 0; id_ready = 0; flush = 0; if_ready = 1;
    start_addr = '0; end_addr = '0; counter = '0;
    #12;
    check("rst_jump", {31'd0, jump}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_target", target, 0);
    check("rst_dec", {30'd0, dec}, 0);
    check("rst_valid", {31'd0, dvalid}, 0);
    rst_n = 1'b1;
    tick();

    // Single loop, three iterations: jump, jump, exit.
    set_loop(0, 32'h100, 32'h110, 32'd3);
    set_loop(1, 32'h0, 32'h0, 32'd0);
    for (int c = 3; c >= 1; c--) begin
      counter[0] = c;
      retire(32'h10C);
      check("single_dec", {30'd0, dec}, 32'h1);
      check("single_valid", {31'd0, dvalid}, 1);
      check("single_nojump_yet", {31'd0, jump}, 0);
      tick();
      check("single_jump", {31'd0, jump}, (c > 1) ? 1 : 0);
      if (c > 1) begin
        check("single_target", target, 32'h100);
        check("single_busy", {31'd0, busy}, 1);
        check("pend_no_dec", {30'd0, dec}, 0);
      end
      id_valid = 0;
      tick();
      check("single_back_idle", {31'd0, jump}, 0);
    end

    // Exit chain: inner loop exits, outer loop jumps.
    set_loop(0, 32'h100, 32'h120, 32'd1);
    set_loop(1, 32'h80, 32'h120, 32'd2);
    retire(32'h11C);
    check("chain_dec", {30'd0, dec}, 32'h3);
    check("chain_valid", {31'd0, dvalid}, 1);
    tick();
    check("chain_jump", {31'd0, jump}, 1);
    check("chain_target", target, 32'h80);
    id_valid = 0;
    tick();

    // Outer loop alone matches.
    set_loop(0, 32'h100, 32'h200, 32'd3);
    set_loop(1, 32'h40, 32'h110, 32'd4);
    retire(32'h10C);
    check("outer_dec", {30'd0, dec}, 32'h2);
    tick();
    check("outer_target", target, 32'h40);
    id_valid = 0;
    tick();

    // Backpressure from IF.
    set_loop(0, 32'h100, 32'h110, 32'd5);
    set_loop(1, 32'h0, 32'h0, 32'd0);
    if_ready = 0;
    retire(32'h10C);
    check("bp_dec", {30'd0, dec}, 32'h1);
    tick();
    counter[0] = 32'd4;
    for (int i = 0; i < 4; i++) begin
      check("bp_jump", {31'd0, jump}, 1);
      check("bp_busy", {31'd0, busy}, 1);
      check("bp_target", target, 32'h100);
      check("bp_no_dec", {30'd0, dec}, 0);
      check("bp_no_valid", {31'd0, dvalid}, 0);
      tick();
    end
    if_ready = 1; id_valid = 0;
    tick();
    check("bp_release", {31'd0, jump}, 0);

    // Flush in the retire cycle.
    flush = 1;
    retire(32'h10C);
    check("flush_ret_dec", {30'd0, dec}, 0);
    check("flush_ret_valid", {31'd0, dvalid}, 0);
    tick();
    check("flush_ret_jump", {31'd0, jump}, 0);
    flush = 0;

    // Flush during a pending jump.
    if_ready = 0;
    retire(32'h10C);
    check("flush_pend_dec", {30'd0, dec}, 32'h1);
    tick();
    check("flush_pend_jump", {31'd0, jump}, 1);
    id_valid = 0; flush = 1;
    tick();
    check("flush_pend_drop", {31'd0, jump}, 0);
    check("flush_pend_busy", {31'd0, busy}, 0);
    flush = 0; if_ready = 1;

    // No-action cases.
    counter[0] = 32'd0;
    retire(32'h10C);
    check("inactive_dec", {30'd0, dec}, 0);
    tick();
    check("inactive_jump", {31'd0, jump}, 0);
    counter[0] = 32'd3;
    id_ready = 0;
    #1;
    check("noready_dec", {30'd0, dec}, 0);
    check("noready_valid", {31'd0, dvalid}, 0);
    tick();
    check("noready_jump", {31'd0, jump}, 0);
    retire(32'h10E);
    check("misalign_dec", {30'd0, dec}, 0);
    set_loop(0, 32'h100, 32'h0, 32'd3);
    retire(32'hFFFF_FFFC);
    check("end0_dec", {30'd0, dec}, 0);
    tick();
    check("end0_jump", {31'd0, jump}, 0);

    // Asynchronous reset while a jump is pending.
    set_loop(0, 32'h100, 32'h110, 32'd3);
    if_ready = 0;
    retire(32'h10C);
    tick();
    check("rstpend_jump", {31'd0, jump}, 1);
    id_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check("arst_jump", {31'd0, jump}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_target", target, 0);
    check("arst_dec", {30'd0, dec}, 0);
    check("arst_valid", {31'd0, dvalid}, 0);
    tick();
    rst_n = 1;
    tick();
    check("post_rst_jump", {31'd0, jump}, 0);
    check("post_rst_target", target, 0);
    retire(32'h10C);
    check("post_rst_idle_dec", {30'd0, dec}, 32'h1);
    tick();
    check("post_rst_jump2", {31'd0, jump}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cve2_hwloop_controller.md
Name: cve2_hwloop_controller

Overview:
- Sequences the hardware-loop register file: watches instructions retiring in ID, detects the last instruction of an active loop, and decides whether to redirect fetch to the loop start or fall through.
- Drives the per-loop decrement strobes and a fetch-redirect handshake toward the IF stage.
- Resolves nested loops: loop 0 is innermost and has highest priority.

Parameters:
- N_REGS, 2, number of hardware loops; loop 0 is innermost.
- N_REG_BITS, $clog2(N_REGS), loop index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_pc_i  in  32  PC of the instruction in ID
- id_instr_valid_i  in  1  instruction in ID is valid and not killed
- id_ready_i  in  1  ID accepts/retires the instruction this cycle
- flush_i  in  1  branch/exception/debug redirect; kills decision and pending jump
- hwlp_start_addr_i  in  N_REGS x 32  loop start addresses, word aligned
- hwlp_end_addr_i  in  N_REGS x 32  loop end addresses, exclusive: last instruction is at end-4
- hwlp_counter_i  in  N_REGS x 32  remaining iterations
- if_ready_i  in  1  IF accepts a redirect this cycle
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement strobe to the register file
- hwlp_valid_o  out  1  qualifies the decrement to the register file (its valid_i)
- hwlp_jump_o  out  1  fetch redirect request
- hwlp_target_o  out  32  redirect target (start address)
- hwlp_busy_o  out  1  jump pending; ID must not issue past the loop end

Behaviour:
- Retire event R = id_instr_valid_i & id_ready_i & ~flush_i & (state == IDLE).
- Loop k is active when hwlp_counter_i[k] != 0.
- Loop k matches when it is active and id_pc_i == hwlp_end_addr_i[k] - 32'd4 (32-bit modular subtract; end == 0 never matches).
- Selection, evaluated for k = 0 upward; stop at the first k that matches:
  - counter > 1: jump to hwlp_start_addr_i[k] and decrement k.
  - counter == 1: decrement k, fall through, and continue evaluating k+1 (an inner loop exits, then the outer loop is tested).
- At most one loop jumps per retire. Decrements may hit several loops in the same cycle only when every lower loop exits (counter == 1).
  - Consequence: the decrement vector is one-hot except for the exit-chain case.
  - The exit chain is legal and documented; any existing "at most one decrement" assertion must be relaxed to match this.
- hwlp_dec_cnt_o and hwlp_valid_o are combinational in the retire cycle, so the register file updates at the same edge. When R is 0, both are 0.
- FSM:
  - IDLE: on R with a jump selected, register the target and go to JUMP_PEND. Otherwise stay in IDLE.
  - JUMP_PEND: hwlp_jump_o = 1, hwlp_target_o = registered target, hwlp_busy_o = 1.
    - if_ready_i: return to IDLE.
    - flush_i (priority over if_ready_i): drop the jump and return to IDLE. The decrement already committed is not undone.
  - Jump latency: retire at cycle t, hwlp_jump_o high from t+1.
- In JUMP_PEND, R is forced 0, so no second decision is taken while a redirect is outstanding.
- flush_i in the same cycle as a retire suppresses the decrement and the jump.
- A register-file write in the same cycle as a match is invisible to the controller this cycle: it uses the _i values present in that cycle.
- Compressed last instructions are unsupported: only a 32-bit instruction at end-4 is matched.
- Reset: state = IDLE, target register = 0. All outputs are 0 (hwlp_target_o = 0) and stay 0 until the first retire.

Decomposition:
- Package cve2_pkg: hwlp_state_e {HWLP_IDLE, HWLP_JUMP_PEND}; constant HWLP_INSTR_BYTES = 4.
- Optional sub-module cve2_hwloop_match: combinational per-loop match plus priority/exit-chain selection, producing the decrement vector, the jump flag and the selected index.
- FSM and target register stay in the top module.

Test Plan:
- Single loop: start=0x100, end=0x110, cnt=3; retire pc 0x10C three times.
  - First two retires: dec[0]=1 and a jump to 0x100 the next cycle.
  - Third retire (cnt=1): dec[0]=1 and no jump.
- Nested exit chain: loop0 end=0x120, cnt=1; loop1 end=0x120, cnt=2, start=0x80; retire 0x11C.
  - dec=2'b11 and a jump to 0x80.
- Backpressure: jump pending to 0x100 with if_ready_i=0 for 4 cycles.
  - hwlp_jump_o and hwlp_busy_o stay high, target stays stable, and there is no second decrement when ID presents 0x10C again.
- Flush: flush_i in the retire cycle gives no dec and no jump. flush_i during JUMP_PEND drops the jump and returns to IDLE next cycle, with the counter already decremented.
- Inactive and misaligned cases: cnt=0 with pc=end-4 gives no action. id_ready_i=0 gives no action. end=0 gives no match.
- Reset mid-JUMP_PEND: assert rst_n=0.
  - All outputs go to 0 immediately, asynchronously.
  - After release the block is in IDLE with target 0.
